// File: rtl/latch_bit_deserializer_if.sv
// Bundle between the serial bit source / word consumer and the deserializer.
// master: the environment side (drives bits, start and word_ready).
// slave: the deserializer side (drives the word and the status flags).
interface latch_bit_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             bit_in;
  logic             bit_valid;
  logic             start;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  modport master (
    output bit_in, bit_valid, start, word_ready,
    input  word_out, word_valid, busy, overrun, parity_err
  );

  modport slave (
    input  bit_in, bit_valid, start, word_ready,
    output word_out, word_valid, busy, overrun, parity_err
  );
endinterface

// File: rtl/latch_bit_deserializer.sv
// Packs a bit_valid-qualified serial stream into WIDTH-bit words; LATCH_DESER_PARITY_EN adds an even-parity bit.
// Latency: the word loads on the edge capturing the last bit (parity bit when enabled), no added cycles.
// Backpressure: single holding register; a word completing while the register is full and not drained sets sticky overrun.
module latch_bit_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  latch_bit_deserializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef LATCH_DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first;
  logic [WIDTH-1:0] next_word;
  logic             done;
  logic             load;
`ifdef LATCH_DESER_PARITY_EN
  logic             next_par;
`endif

  // Place the incoming bit in arrival order: shift from the chosen end.
  always_comb begin
    if (MSB_FIRST) begin
      shifted = {sreg[WIDTH-2:0], bus.bit_in};
      first   = {{(WIDTH-1){1'b0}}, bus.bit_in};
    end else begin
      shifted = {bus.bit_in, sreg[WIDTH-1:1]};
      first   = {bus.bit_in, {(WIDTH-1){1'b0}}};
    end
  end

  // Frame completion detect; start always wins over completion.
  always_comb begin
    done      = 1'b0;
    next_word = shifted;
`ifdef LATCH_DESER_PARITY_EN
    next_par  = 1'b0;
    if (state == PAR && !bus.start && bus.bit_valid) begin
      done      = 1'b1;
      next_word = sreg;
      next_par  = ^{sreg, bus.bit_in};
    end
`else
    if (state == SHIFT && !bus.start && bus.bit_valid && count == LAST) begin
      done = 1'b1;
    end
`endif
  end

  // Load is legal when the holding register is empty or drains on this edge.
  assign load = done && (!bus.word_valid || bus.word_ready);

`ifndef LATCH_DESER_PARITY_EN
  assign bus.parity_err = 1'b0;
`endif

  // Frame FSM plus holding register and status flags, all registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      sreg           <= '0;
      bus.word_out   <= '0;
      bus.word_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.overrun    <= 1'b0;
`ifdef LATCH_DESER_PARITY_EN
      bus.parity_err <= 1'b0;
`endif
    end else begin
      if (load) begin
        bus.word_out   <= next_word;
        bus.word_valid <= 1'b1;
`ifdef LATCH_DESER_PARITY_EN
        bus.parity_err <= next_par;
`endif
      end else if (bus.word_valid && bus.word_ready) begin
        bus.word_valid <= 1'b0;
      end
      if (done && !load) begin
        bus.overrun <= 1'b1;
      end

      if (bus.start) begin
        // New frame or resync from any state; a same-edge bit is bit 0.
        state    <= SHIFT;
        bus.busy <= 1'b1;
        sreg     <= bus.bit_valid ? first : '0;
        count    <= bus.bit_valid ? CW'(1) : '0;
      end else if (done) begin
        state    <= IDLE;
        bus.busy <= 1'b0;
        count    <= '0;
      end else if (state == SHIFT && bus.bit_valid) begin
        sreg  <= shifted;
        count <= count + CW'(1);
`ifdef LATCH_DESER_PARITY_EN
        if (count == LAST) begin
          state <= PAR;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_latch_bit_deserializer.sv
// Directed bench: reset, LSB/MSB packing, gaps, backpressure/overrun, abort, mid-frame reset, parity.
// Two instances share stimulus: MSB_FIRST=0 (main) and MSB_FIRST=1 (ordering only).
// Outputs are sampled 1 time unit after each rising edge.
module tb_latch_bit_deserializer;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  latch_bit_deserializer_if #(.WIDTH(8)) ifl ();
  latch_bit_deserializer_if #(.WIDTH(8)) ifm ();

  assign ifm.bit_in     = ifl.bit_in;
  assign ifm.bit_valid  = ifl.bit_valid;
  assign ifm.start      = ifl.start;
  assign ifm.word_ready = ifl.word_ready;

  latch_bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock),
    .reset(reset),
    .bus  (ifl.slave)
  );

  latch_bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clock(clock),
    .reset(reset),
    .bus  (ifm.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put_bit(input logic b, input logic st);
    ifl.start     = st;
    ifl.bit_valid = 1'b1;
    ifl.bit_in    = b;
    step();
    ifl.start     = 1'b0;
    ifl.bit_valid = 1'b0;
  endtask

  // Sends d LSB first (start on the first bit); rdy is applied for the completing edge.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic rdy);
    for (int i = 0; i < 8; i++) begin
`ifndef LATCH_DESER_PARITY_EN
      if (i == 7) ifl.word_ready = rdy;
`endif
      put_bit(d[i], i == 0);
    end
`ifdef LATCH_DESER_PARITY_EN
    ifl.word_ready = rdy;
    put_bit(p, 1'b0);
`else
    if (p === 1'bx) $display("unused parity bit");
`endif
  endtask

  initial begin
    logic [7:0] d;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    ifl.bit_in     = 1'b0;
    ifl.bit_valid  = 1'b0;
    ifl.start      = 1'b0;
    ifl.word_ready = 1'b0;

    // 1: reset held with inputs toggling
    for (int i = 0; i < 4; i++) begin
      ifl.bit_valid = i[0];
      ifl.start     = ~i[0];
      ifl.bit_in    = i[1];
      step();
    end
    chk("rst_word_out", {24'd0, ifl.word_out}, 32'h0);
    chk("rst_word_valid", ifl.word_valid, 0);
    chk("rst_busy", ifl.busy, 0);
    chk("rst_overrun", ifl.overrun, 0);
    chk("rst_parity_err", ifl.parity_err, 0);
    ifl.bit_valid = 1'b0;
    ifl.start     = 1'b0;
    reset = 1'b1;
    step();
    step();
    chk("post_rst_valid", ifl.word_valid, 0);
    chk("post_rst_busy", ifl.busy, 0);

    // 2: 8'h4D, LSB-first and MSB-first packing
    ifl.word_ready = 1'b1;
    send_frame(8'h4D, 1'b0, 1'b1);
    chk("t2_word_lsb", {24'd0, ifl.word_out}, 32'h4D);
    chk("t2_word_msb", {24'd0, ifm.word_out}, 32'hB2);
    chk("t2_valid", ifl.word_valid, 1);
    chk("t2_busy", ifl.busy, 0);
    step();
    chk("t2_drained", ifl.word_valid, 0);

    // 3: same bits with two-cycle gaps after bits 3 and 6
    put_bit(1'b1, 1'b1);
    put_bit(1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    step();
    step();
    chk("t3_busy_gap1", ifl.busy, 1);
    put_bit(1'b1, 1'b0);
    put_bit(1'b0, 1'b0);
    put_bit(1'b0, 1'b0);
    step();
    step();
    chk("t3_busy_gap2", ifl.busy, 1);
    chk("t3_not_done", ifl.word_valid, 0);
    put_bit(1'b1, 1'b0);
    put_bit(1'b0, 1'b0);
`ifdef LATCH_DESER_PARITY_EN
    put_bit(1'b0, 1'b0);
`endif
    chk("t3_word", {24'd0, ifl.word_out}, 32'h4D);
    chk("t3_valid", ifl.word_valid, 1);
    step();

    // legal load while full: consumer drains on the completing edge
    ifl.word_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0);
    chk("ll_first", {24'd0, ifl.word_out}, 32'h11);
    send_frame(8'h22, 1'b0, 1'b1);
    ifl.word_ready = 1'b0;
    chk("ll_word", {24'd0, ifl.word_out}, 32'h22);
    chk("ll_valid", ifl.word_valid, 1);
    chk("ll_no_overrun", ifl.overrun, 0);
    ifl.word_ready = 1'b1;
    step();
    ifl.word_ready = 1'b0;
    chk("ll_drained", ifl.word_valid, 0);

    // 4: backpressure overrun
    send_frame(8'hA5, 1'b0, 1'b0);
    chk("t4_first", {24'd0, ifl.word_out}, 32'hA5);
    send_frame(8'h3C, 1'b1, 1'b0);
    chk("t4_overrun", ifl.overrun, 1);
    chk("t4_word_kept", {24'd0, ifl.word_out}, 32'hA5);
    chk("t4_valid_kept", ifl.word_valid, 1);
    chk("t4_perr_kept", ifl.parity_err, 0);
    ifl.word_ready = 1'b1;
    step();
    ifl.word_ready = 1'b0;
    chk("t4_drained", ifl.word_valid, 0);
    chk("t4_overrun_sticky", ifl.overrun, 1);

    // 5: abort after 3 bits, then a full 8'h4D
    d = 8'h4D;
    put_bit(1'b1, 1'b1);
    put_bit(1'b1, 1'b0);
    put_bit(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) put_bit(d[i], i == 0);
    chk("t5_no_early", ifl.word_valid, 0);
    chk("t5_busy", ifl.busy, 1);
    put_bit(d[7], 1'b0);
`ifdef LATCH_DESER_PARITY_EN
    put_bit(1'b0, 1'b0);
`endif
    chk("t5_word", {24'd0, ifl.word_out}, 32'h4D);
    chk("t5_valid", ifl.word_valid, 1);

    // mid-frame asynchronous reset
    put_bit(1'b1, 1'b1);
    put_bit(1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    put_bit(1'b1, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_rst_busy", ifl.busy, 0);
    chk("t5_rst_valid", ifl.word_valid, 0);
    chk("t5_rst_word", {24'd0, ifl.word_out}, 32'h0);
    chk("t5_rst_overrun", ifl.overrun, 0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) put_bit(1'b1, 1'b0);
    chk("t5_idle_ignores", ifl.word_valid, 0);
    chk("t5_idle_busy", ifl.busy, 0);

    // 6: parity result (tied low without the parity build)
    ifl.word_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) put_bit(d[i], i == 0);
`ifdef LATCH_DESER_PARITY_EN
      chk("t6_not_on_8th", ifl.word_valid, 0);
      put_bit(k[0], 1'b0);
      chk("t6_perr", ifl.parity_err, k[0]);
`else
      chk("t6_perr", ifl.parity_err, 0);
`endif
      chk("t6_word", {24'd0, ifl.word_out}, 32'h4D);
      chk("t6_valid", ifl.word_valid, 1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
